// File: rtl/micro_tile_pkg.sv
// micro_tile_pkg: shared state encoding, default sizing and tile decode for the tile sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package micro_tile_pkg;

  localparam int NUM_TILES_DEF = 4;
  localparam int SEL_W_DEF     = 2;
  localparam int MAX_TILES     = 8;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_HOLD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GATE  = 3'd4
  } state_e;

  // One-hot decode of a tile index; callers size-cast down to their tile count.
  function automatic logic [MAX_TILES-1:0] tile_onehot(input logic [2:0] sel);
    tile_onehot      = '0;
    tile_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/micro_tile_sel_filter.sv
// micro_tile_sel_filter: synchronises pad select and tile reset request, debounces select.
// Latency: SYNC_STAGES flops, then STABLE_CYCLES identical samples before stable_sel loads.
// Backpressure: none; out-of-range selects are dropped and stable_sel holds its old value.
module micro_tile_sel_filter #(
  parameter int NUM_TILES     = 4,
  parameter int SEL_W         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_req,
  input  logic             ext_rst_n,
  output logic [SEL_W-1:0] stable_sel,
  output logic             ext_rst_n_sync
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SEL_W-1:0]       sel_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic [SEL_W-1:0]       sel_s;
  logic [SEL_W-1:0]       prev_q;
  logic [SEL_W-1:0]       stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign sel_s          = sel_sync_q[SYNC_STAGES-1];
  assign stable_sel     = stable_q;
  assign ext_rst_n_sync = ext_sync_q[SYNC_STAGES-1];

  // Count consecutive equal samples; accept a select once the run is long enough and in range.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sel_s == prev_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    end
    if ((cnt_d == CNT_MAX) && (32'(sel_s) < 32'(NUM_TILES))) begin
      stable_d = sel_s;
    end
  end

  // Synchroniser chains plus filter state; reset treats the tile reset request as asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sel_sync_q[i] <= '0;
      end
      ext_sync_q <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      stable_q   <= '0;
    end else begin
      sel_sync_q[0] <= sel_req;
      ext_sync_q[0] <= ext_rst_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sel_sync_q[i] <= sel_sync_q[i-1];
        ext_sync_q[i] <= ext_sync_q[i-1];
      end
      prev_q   <= sel_s;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/micro_tile_sequencer.sv
// micro_tile_sequencer: safe tile switchover -- drain old tile, gate clocks, swap mux, hold new tile in reset, release.
// Latency: registered outputs; RUN detect at t drops out_valid at t+1 and restores it at t+3+RST_HOLD.
// Backpressure: none; select changes mid-sequence are taken at GATE or on the next RUN cycle. Macro MICRO_TILE_SWITCH_CNT_EN builds switch_cnt.
module micro_tile_sequencer
  import micro_tile_pkg::*;
#(
  parameter int NUM_TILES     = NUM_TILES_DEF,
  parameter int SEL_W         = SEL_W_DEF,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int RST_HOLD      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_W-1:0]     sel_req,
  input  logic                 ext_rst_n,
  output logic [NUM_TILES-1:0] tile_clk_en,
  output logic [NUM_TILES-1:0] tile_rst_n,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  output logic                 busy,
  output logic [7:0]           switch_cnt
);

  localparam int              HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

  logic [SEL_W-1:0]     stable_sel;
  logic                 ext_rst_n_sync;
  state_e               state_q, state_d;
  logic [SEL_W-1:0]     active_q, active_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [NUM_TILES-1:0] oh_d, clk_en_d, rst_n_d;
  logic [NUM_TILES-1:0] clk_en_q, rst_n_q;
  logic [SEL_W-1:0]     out_sel_q;
  logic                 out_valid_q, busy_q;

  micro_tile_sel_filter #(
    .NUM_TILES    (NUM_TILES),
    .SEL_W        (SEL_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk           (clk),
    .rst           (rst),
    .sel_req       (sel_req),
    .ext_rst_n     (ext_rst_n),
    .stable_sel    (stable_sel),
    .ext_rst_n_sync(ext_rst_n_sync)
  );

  // Switchover sequencing; the new tile index is latched on the way into GATE so HOLD clocks it.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    hold_d   = hold_q;
    unique case (state_q)
      ST_START: begin
        state_d = ST_HOLD;
        hold_d  = HOLD_INIT;
      end
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_RUN;
        else              hold_d  = hold_q - 1'b1;
      end
      ST_RUN: begin
        if (stable_sel != active_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d  = ST_GATE;
        active_d = stable_sel;
      end
      ST_GATE: begin
        state_d = ST_HOLD;
        hold_d  = HOLD_INIT;
      end
      default: state_d = ST_START;
    endcase
  end

  // Decode next-cycle outputs from the next state so every output leaves a flop.
  always_comb begin
    oh_d     = NUM_TILES'(tile_onehot(3'(active_d)));
    clk_en_d = '0;
    rst_n_d  = '0;
    if (state_d inside {ST_HOLD, ST_RUN, ST_DRAIN}) clk_en_d = oh_d;
    if ((state_d == ST_RUN) && ext_rst_n_sync)      rst_n_d  = oh_d;
  end

  // State and output registers; reset parks every tile gated and in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_START;
      active_q    <= '0;
      hold_q      <= '0;
      clk_en_q    <= '0;
      rst_n_q     <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      hold_q      <= hold_d;
      clk_en_q    <= clk_en_d;
      rst_n_q     <= rst_n_d;
      out_sel_q   <= active_d;
      out_valid_q <= (state_d == ST_RUN);
      busy_q      <= (state_d != ST_RUN);
    end
  end

  assign tile_clk_en = clk_en_q;
  assign tile_rst_n  = rst_n_q;
  assign out_sel     = out_sel_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;

`ifdef MICRO_TILE_SWITCH_CNT_EN
  logic [7:0] switch_cnt_q;

  // Count switchovers as they pass GATE, holding at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      switch_cnt_q <= '0;
    end else if ((state_d == ST_GATE) && (switch_cnt_q != 8'hFF)) begin
      switch_cnt_q <= switch_cnt_q + 8'd1;
    end
  end

  assign switch_cnt = switch_cnt_q;
`else
  assign switch_cnt = 8'h00;
`endif

endmodule
